scan_beta_mem_p: RTL
====================

Name: scan_beta_mem_p

Overview:
- Parametrised partial-sum (beta) storage for the SCAN polar decoder; holds the hard/soft beta values of every intermediate layer between the P-wide PE array and the tree controller.
- Generalises the fixed N=1024/P=16 beta RAM to any power-of-two N and P, using one flat layer-packed array.
- Adds a read-valid output, a write-first bypass, a synchronous codeword flush, and sticky out-of-range error detection.

Parameters:
- Q, 6, bits per beta entry
- P, 16, PE parallelism (entries per read beat; a write beat is 2P entries); power of two, >=2
- N, 1024, code length; power of two, N >= 8P
- LW, 5, width of layer select ports
- CW, 6, width of beat counter ports

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous flush: zero all storage and err
- w_en  in  1  write strobe
- layer_w  in  LW  write layer, valid range 1..LMAX (LMAX = log2(N)-2)
- cnta  in  CW  write beat index
- b_in  in  2*P*Q  write data: lo half [P*Q-1:0], hi half [2PQ-1:PQ], entry i at bits [i*Q+:Q]
- r_en  in  1  read strobe
- layer_r  in  LW  read layer
- cntb  in  CW  read beat index
- b_out  out  P*Q  read data, registered
- rd_valid  out  1  b_out holds a read result
- err  out  1  sticky illegal-access flag

Behaviour:
- Storage: layer l (1..LMAX) holds S_l = 2^l entries at flat base 2^l - 2; total 2^(LMAX+1)-2 entries of Q bits.
- Write, S_l >= 2P: lo entries j -> layer entry cnta*P+j; hi entries j -> S_l/2 + cnta*P + j; j = 0..P-1. Legal iff cnta < S_l/(2P).
- Write, S_l < 2P: H = S_l/2; lo entries 0..H-1 -> entries 0..H-1; hi entries 0..H-1 -> H..S_l-1. Legal iff cnta == 0.
- Read, S_l >= P: b_out entry j = layer entry cntb*P+j. Legal iff cntb < S_l/P.
- Read, S_l < P: entries 0..S_l-1 on b_out low positions; remaining positions zero. Legal iff cntb == 0.
- Read latency 1: b_out/rd_valid update on the clk edge after r_en is sampled. When r_en is low, b_out <= 0 and rd_valid <= 0 on the next edge.
- Illegal access (layer outside 1..LMAX, or beat index out of range):
  - illegal write: storage unchanged, err <= 1
  - illegal read: b_out <= 0, rd_valid <= 1, err <= 1
- Simultaneous w_en and r_en on the same layer: write-first. Each read entry that the write touches returns the new b_in value; other entries return stored data.
- clr has priority over w_en and r_en in the same cycle: storage and err zeroed, b_out <= 0, rd_valid <= 0, the write is dropped. Takes effect on the next edge.
- rst (any time, including mid-codeword): all storage, b_out, rd_valid and err go to 0 immediately. The first edge after deassertion is a normal cycle.
- Reset values: b_out = 0, rd_valid = 0, err = 0, all entries 0.
- err is cleared only by rst or clr.
- Arithmetic: all addresses are computed from LMAX with unsigned math, wide enough to hold 2^(LMAX+1). No wrap-around: out-of-range indices are flagged as errors, never aliased.

Decomposition:
- Package scan_beta_pkg:
  - constants LMAX, TOTAL_ENTRIES
  - functions layer_base(l), layer_size(l), wr_legal(l, cnt), rd_legal(l, cnt)
  - entry typedef of Q bits
- One natural sub-module, scan_beta_addr_gen (combinational): maps layer/beat to per-entry flat addresses, a per-entry enable mask and a legal flag. Instantiated once for the write side and once for the read side.

Test Plan (Q=6, P=16, N=1024, LMAX=8):
- Layer 8 write cnta=3, lo entries = 1..16, hi = 17..32; read layer 8 cntb=3 -> entries 1..16, rd_valid=1 one cycle after r_en. Read cntb=11 -> 17..32.
- Layer 3 write cnta=0, lo entries 0..3 = 5,6,7,8, hi entries 0..3 = 9,10,11,12; read layer 3 cntb=0 -> entries 0..7 = 5..12, entries 8..15 = 0.
- Same cycle: write layer 6 cnta=0 with all entries 0x2A, read layer 6 cntb=0 (previously 0x01) -> b_out all 0x2A. A read of layer 6 cntb=1 in the same cycle returns the old data.
- Write layer 7 cnta=4 (limit 4) -> storage unchanged, err=1. Read layer 9 -> b_out=0, rd_valid=1, err stays 1. Pulse clr -> err=0 and every layer reads back zero.
- Assert rst asynchronously between edges during a write burst -> b_out, rd_valid and err drop to 0 before the next edge. Reads after release return 0.
- r_en low for 3 cycles after valid data -> b_out=0 and rd_valid=0 from the first following edge.

Source files
------------

// File: rtl/scan_beta_pkg.sv
// Shared constants and layer geometry helpers for the SCAN beta storage.
// Pure definitions: no latency and no flow control.
package scan_beta_pkg;

    localparam int Q_DEF         = 6;
    localparam int N_DEF         = 1024;
    localparam int LMAX          = $clog2(N_DEF) - 2;
    localparam int TOTAL_ENTRIES = (2 ** (LMAX + 1)) - 2;

    typedef logic [Q_DEF-1:0] entry_t;

    function automatic int layer_base(input int l);
        return (1 << l) - 2;
    endfunction

    function automatic int layer_size(input int l);
        return 1 << l;
    endfunction

    function automatic logic layer_ok(input int l, input int lmax);
        return (l >= 1) && (l <= lmax);
    endfunction

    // Layer validity is checked first so layer_size is never evaluated on a wild layer.
    function automatic logic wr_legal(input int l, input int cnt, input int p, input int lmax);
        if (!layer_ok(l, lmax))
            return 1'b0;
        if (layer_size(l) >= 2 * p)
            return cnt < layer_size(l) / (2 * p);
        return cnt == 0;
    endfunction

    function automatic logic rd_legal(input int l, input int cnt, input int p, input int lmax);
        if (!layer_ok(l, lmax))
            return 1'b0;
        if (layer_size(l) >= p)
            return cnt < layer_size(l) / p;
        return cnt == 0;
    endfunction

endpackage

// File: rtl/scan_beta_addr_gen.sv
// Maps a layer/beat pair onto per-entry flat addresses, an entry enable mask and a legal flag.
// Combinational, zero latency; no flow control.
module scan_beta_addr_gen
    import scan_beta_pkg::*;
#(
    parameter int P  = 16,
    parameter int N  = 1024,
    parameter int LW = 5,
    parameter int CW = 6,
    parameter int E  = 32,
    parameter bit WR = 1'b1,
    parameter int AW = 9
) (
    input  logic [LW-1:0]        layer,
    input  logic [CW-1:0]        cnt,
    output logic [E-1:0][AW-1:0] addr,
    output logic [E-1:0]         mask,
    output logic                 legal
);

    localparam int LM = $clog2(N) - 2;

    int   l, c, s, base, ent, half, j;
    logic m;

    always_comb begin
        l     = int'(layer);
        c     = int'(cnt);
        legal = WR ? wr_legal(l, c, P, LM) : rd_legal(l, c, P, LM);
        s     = layer_ok(l, LM) ? layer_size(l) : 2;
        base  = layer_ok(l, LM) ? layer_base(l) : 0;
        addr  = '0;
        mask  = '0;
        ent   = 0;
        half  = 0;
        j     = 0;
        m     = 1'b0;
        for (int i = 0; i < E; i++) begin
            j    = i % P;
            half = i / P;
            // Write beats carry a lo and a hi half that land in the two halves of the layer.
            if (WR) begin
                if (s >= 2 * P) begin
                    ent = half * (s / 2) + c * P + j;
                    m   = 1'b1;
                end else begin
                    ent = half * (s / 2) + j;
                    m   = j < s / 2;
                end
            end else begin
                if (s >= P) begin
                    ent = c * P + j;
                    m   = 1'b1;
                end else begin
                    ent = j;
                    m   = j < s;
                end
            end
            mask[i] = legal && m;
            addr[i] = mask[i] ? AW'(base + ent) : '0;
        end
    end

endmodule

// File: rtl/scan_beta_mem_p.sv
// Layer-packed beta storage: one 2P-entry write beat and one P-entry read beat per cycle.
// Read data registered with 1-cycle latency and write-first bypass; no backpressure.
module scan_beta_mem_p
    import scan_beta_pkg::*;
#(
    parameter int Q  = 6,
    parameter int P  = 16,
    parameter int N  = 1024,
    parameter int LW = 5,
    parameter int CW = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              w_en,
    input  logic [LW-1:0]     layer_w,
    input  logic [CW-1:0]     cnta,
    input  logic [2*P*Q-1:0]  b_in,
    input  logic              r_en,
    input  logic [LW-1:0]     layer_r,
    input  logic [CW-1:0]     cntb,
    output logic [P*Q-1:0]    b_out,
    output logic              rd_valid,
    output logic              err
);

    localparam int LM  = $clog2(N) - 2;
    localparam int TOT = (2 ** (LM + 1)) - 2;
    localparam int AW  = $clog2(TOT);

    logic [Q-1:0]              mem [TOT];
    logic [2*P-1:0][AW-1:0]    waddr;
    logic [2*P-1:0]            wmask;
    logic                      wlegal;
    logic [P-1:0][AW-1:0]      raddr;
    logic [P-1:0]              rmask;
    logic                      rlegal;
    logic [P*Q-1:0]            rd_dat;

    scan_beta_addr_gen #(
        .P(P), .N(N), .LW(LW), .CW(CW), .E(2 * P), .WR(1'b1), .AW(AW)
    ) u_wr_addr (
        .layer (layer_w),
        .cnt   (cnta),
        .addr  (waddr),
        .mask  (wmask),
        .legal (wlegal)
    );

    scan_beta_addr_gen #(
        .P(P), .N(N), .LW(LW), .CW(CW), .E(P), .WR(1'b0), .AW(AW)
    ) u_rd_addr (
        .layer (layer_r),
        .cnt   (cntb),
        .addr  (raddr),
        .mask  (rmask),
        .legal (rlegal)
    );

    // Flat addresses are unique across layers, so an address match implies the same layer.
    always_comb begin
        rd_dat = '0;
        for (int j = 0; j < P; j++) begin
            if (rmask[j]) begin
                rd_dat[j*Q+:Q] = mem[raddr[j]];
                for (int i = 0; i < 2 * P; i++) begin
                    if (w_en && wmask[i] && (waddr[i] == raddr[j]))
                        rd_dat[j*Q+:Q] = b_in[i*Q+:Q];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TOT; k++)
                mem[k] <= '0;
            b_out    <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else if (clr) begin
            for (int k = 0; k < TOT; k++)
                mem[k] <= '0;
            b_out    <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (w_en) begin
                if (wlegal) begin
                    for (int i = 0; i < 2 * P; i++)
                        if (wmask[i])
                            mem[waddr[i]] <= b_in[i*Q+:Q];
                end else begin
                    err <= 1'b1;
                end
            end
            if (r_en) begin
                rd_valid <= 1'b1;
                b_out    <= rlegal ? rd_dat : '0;
                if (!rlegal)
                    err <= 1'b1;
            end else begin
                rd_valid <= 1'b0;
                b_out    <= '0;
            end
        end
    end

endmodule
